// File: rtl/ias_pkg.sv
// Shared definitions for the inc/dec/neg scan pipeline: op encodings and chain sizing.
package ias_pkg;

  typedef enum logic [1:0] {
    OP_PASS = 2'b00,
    OP_INC  = 2'b01,
    OP_DEC  = 2'b10,
    OP_NEG  = 2'b11
  } op_e;

  // Per-stage overhead on top of the data word: valid bit plus two op bits.
  localparam int STATE_EXTRA = 3;

  function automatic int scan_len(input int width, input int stages);
    return stages * (width + STATE_EXTRA);
  endfunction

endpackage

// File: rtl/ias_scan_stage.sv
// W-bit register that either loads a parallel word or shifts one bit of the scan chain.
module ias_scan_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         sen,
  input  logic         ce,
  input  logic         sin,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         sout
);

  // Shift moves toward the MSB so sin lands in bit 0 and the MSB leaves first.
  always_ff @(posedge clk or posedge clr) begin
    if (clr)     q <= '0;
    else if (ce) q <= sen ? {q[W-2:0], sin} : d;
  end

  assign sout = q[W-1];

endmodule

// File: rtl/ias_pipe_datapath.sv
// Elastic valid/ready pipeline with a per-item op in stage 1; every state bit sits on one scan chain.
module ias_pipe_datapath
  import ias_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int STEP   = 1,
  parameter int SAT    = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic [1:0]       op_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             sin,
  output logic             sout,
  input  logic             sen,
  input  logic             scan_ce
);

  localparam int SW = WIDTH + STATE_EXTRA;
  localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0] ONE_X  = {{WIDTH{1'b0}}, 1'b1};

  logic [STAGES-1:0][SW-1:0] s_d, s_q;
  logic [STAGES-1:0]         v, adv, ce;
  logic [STAGES:0]           chain;
  logic                      unused_op;

  // One extra bit of headroom exposes carry/borrow for the saturating clamp.
  function automatic logic [WIDTH-1:0] apply_op(input op_e op, input logic [WIDTH-1:0] d);
    logic [WIDTH:0] r;
    r = {1'b0, d};
    case (op)
      OP_INC: begin
        r = {1'b0, d} + STEP_X;
        if (SAT != 0 && r[WIDTH]) r = {1'b0, {WIDTH{1'b1}}};
      end
      OP_DEC: begin
        r = {1'b0, d} - STEP_X;
        if (SAT != 0 && r[WIDTH]) r = '0;
      end
      OP_NEG:  r = {1'b0, ~d} + ONE_X;
      default: r = {1'b0, d};
    endcase
    return r[WIDTH-1:0];
  endfunction

  // adv_k = !v_k | adv_{k+1}, unrolled so each bit depends only on valid bits and out_ready.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      v[k]   = s_q[k][SW-1];
      adv[k] = out_ready;
      for (int j = k; j < STAGES; j++)
        if (!s_q[j][SW-1]) adv[k] = 1'b1;
      ce[k]  = sen ? scan_ce : adv[k];
    end
  end

  always_comb begin
    s_d = '0;
    if (in_valid) s_d[0] = {1'b1, op_in, data_in};
    if (v[0])     s_d[1] = {1'b1, s_q[0][WIDTH +: 2],
                            apply_op(op_e'(s_q[0][WIDTH +: 2]), s_q[0][WIDTH-1:0])};
    for (int k = 2; k < STAGES; k++) s_d[k] = s_q[k-1];
  end

  assign chain[0] = sin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    ias_scan_stage #(.W(SW)) u_stage (
      .clk  (clk),
      .clr  (reset),
      .sen  (sen),
      .ce   (ce[k]),
      .sin  (chain[k]),
      .d    (s_d[k]),
      .q    (s_q[k]),
      .sout (chain[k+1])
    );
  end

  assign in_ready  = adv[0] & ~sen;
  assign out_valid = v[STAGES-1] & ~sen;
  assign data_out  = s_q[STAGES-1][WIDTH-1:0];
  assign sout      = chain[STAGES];

  // The last stage's op bits only travel the scan chain.
  assign unused_op = ^s_q[STAGES-1][WIDTH +: 2];

endmodule

// File: tb/tb_ias_pipe_datapath.sv
// Directed + random bench for ias_pipe_datapath against a queue-based reference model.
module tb_ias_pipe_datapath;
  import ias_pkg::*;

  localparam int STG = 3;
  localparam int L   = scan_len(8, STG);

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic [1:0] op_in;
  logic       in_valid, out_ready, sin, sen, scan_ce;
  logic       in_ready, out_valid, sout;
  logic [7:0] data_out;
  logic       in_ready_b, out_valid_b, sout_b;
  logic [7:0] data_out_b;
  logic       in_ready_c, out_valid_c, sout_c;
  logic [7:0] data_out_c;

  int ntests = 0;
  int nfail  = 0;
  int npop   = 0;
  int qa[$], qb[$], qc[$];

  always #5 clk = ~clk;

  ias_pipe_datapath #(.WIDTH(8), .STAGES(STG), .STEP(1), .SAT(0)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .op_in(op_in), .in_valid(in_valid),
    .in_ready(in_ready), .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready),
    .sin(sin), .sout(sout), .sen(sen), .scan_ce(scan_ce));

  // Saturating variants loop their own chain back so scanning leaves them intact.
  ias_pipe_datapath #(.WIDTH(8), .STAGES(STG), .STEP(1), .SAT(1)) dut_b (
    .clk(clk), .reset(reset), .data_in(data_in), .op_in(op_in), .in_valid(in_valid),
    .in_ready(in_ready_b), .data_out(data_out_b), .out_valid(out_valid_b), .out_ready(out_ready),
    .sin(sout_b), .sout(sout_b), .sen(sen), .scan_ce(scan_ce));

  ias_pipe_datapath #(.WIDTH(8), .STAGES(STG), .STEP(3), .SAT(1)) dut_c (
    .clk(clk), .reset(reset), .data_in(data_in), .op_in(op_in), .in_valid(in_valid),
    .in_ready(in_ready_c), .data_out(data_out_c), .out_valid(out_valid_c), .out_ready(out_ready),
    .sin(sout_c), .sout(sout_c), .sen(sen), .scan_ce(scan_ce));

  function automatic int ref_op(input int op, input int d, input int step, input int sat);
    int r;
    case (op)
      1:       r = d + step;
      2:       r = d - step;
      3:       return (256 - d) % 256;
      default: r = d;
    endcase
    if (sat != 0) begin
      if (r > 255) r = 255;
      if (r < 0)   r = 0;
    end
    return (r + 256) % 256;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    ntests++;
    assert (obs === want) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    if (sen) begin
      chk("scan_in_ready", in_ready, 0);
      chk("scan_out_valid", out_valid, 0);
    end else begin
      chk("in_ready", in_ready, (qa.size() < STG) || out_ready);
      chk("in_ready_b", in_ready_b, (qb.size() < STG) || out_ready);
      chk("in_ready_c", in_ready_c, (qc.size() < STG) || out_ready);
      if (qa.size() == 0) chk("empty_out_valid", out_valid, 0);
      if (out_valid && out_ready && qa.size() != 0) begin
        chk("data_out", data_out, qa.pop_front());
        chk("data_out_b", data_out_b, qb.pop_front());
        chk("data_out_c", data_out_c, qc.pop_front());
        npop++;
      end
      if (in_valid && in_ready) begin
        qa.push_back(ref_op(op_in, data_in, 1, 0));
        qb.push_back(ref_op(op_in, data_in, 1, 1));
        qc.push_back(ref_op(op_in, data_in, 3, 1));
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    sample();
    adv();
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    op_in    = 2'b00;
    data_in  = 8'h00;
  endtask

  task automatic drain();
    idle_in();
    out_ready = 1'b1;
    for (int i = 0; i < 20 && qa.size() != 0; i++) tick();
    chk("drain_empty", qa.size(), 0);
    tick();
  endtask

  // Single item into an empty pipe; checks exact 3-cycle latency.
  task automatic push_one(input logic [1:0] op, input logic [7:0] d,
                          output logic [7:0] oa, output logic [7:0] ob, output logic [7:0] oc);
    in_valid = 1'b1; op_in = op; data_in = d; out_ready = 1'b1;
    sample();
    chk("accept", in_ready, 1);
    adv();
    idle_in();
    oa = 8'h00; ob = 8'h00; oc = 8'h00;
    for (int i = 1; i <= 3; i++) begin
      sample();
      chk("latency_valid", out_valid, (i == 3));
      if (i == 3) begin oa = data_out; ob = data_out_b; oc = data_out_c; end
      adv();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]   oa, ob, oc, da, db, ra, rb;
    logic [L-1:0] pre, g, o;
    int           acc, p0;

    reset = 1'b1; sen = 1'b0; scan_ce = 1'b0; sin = 1'b0; out_ready = 1'b1;
    idle_in();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_sout", sout, 0);
    chk("rst_in_ready", in_ready, 1);
    reset = 1'b0;

    // Reset mid-stream clears immediately, then accept on the first edge after release.
    out_ready = 1'b0;
    in_valid = 1'b1; op_in = OP_INC; data_in = 8'h33; tick();
    data_in = 8'h44; tick();
    #2 reset = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_data_out", data_out, 8'h00);
    chk("midrst_sout", sout, 0);
    chk("midrst_in_ready", in_ready, 1);
    qa.delete(); qb.delete(); qc.delete();
    adv();
    reset = 1'b0;

    push_one(OP_INC, 8'h7F, oa, ob, oc);
    chk("inc_7f", oa, 8'h80);
    push_one(OP_NEG, 8'h05, oa, ob, oc);
    chk("neg_05", oa, 8'hFB);
    chk("neg_05_sat", ob, 8'hFB);

    push_one(OP_INC, 8'hFF, oa, ob, oc);
    chk("wrap_inc_ff", oa, 8'h00);
    chk("sat_inc_ff", ob, 8'hFF);
    chk("sat3_inc_ff", oc, 8'hFF);
    push_one(OP_DEC, 8'h00, oa, ob, oc);
    chk("wrap_dec_00", oa, 8'hFF);
    chk("sat_dec_00", ob, 8'h00);
    chk("sat3_dec_00", oc, 8'h00);
    push_one(OP_INC, 8'hFE, oa, ob, oc);
    chk("sat3_inc_fe", oc, 8'hFF);
    chk("wrap_inc_fe", oa, 8'hFF);

    // Backpressure: only STAGES items fit while the sink stalls.
    out_ready = 1'b0; acc = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1; op_in = OP_INC; data_in = 8'(8'h10 + acc);
      sample();
      if (in_ready) acc++;
      adv();
    end
    chk("bp_accepted", acc, 3);
    sample();
    chk("bp_in_ready", in_ready, 0);
    chk("bp_hold", data_out, 8'h11);
    adv();
    out_ready = 1'b1;
    for (int c = 0; c < 20 && acc < 5; c++) begin
      in_valid = 1'b1; op_in = OP_INC; data_in = 8'(8'h10 + acc);
      sample();
      if (in_ready) acc++;
      adv();
    end
    chk("bp_all_accepted", acc, 5);
    drain();

    // Scan dump and restore of two in-flight items.
    da = 8'($urandom_range(0, 255));
    db = 8'($urandom_range(0, 255));
    out_ready = 1'b0;
    in_valid = 1'b1; op_in = OP_INC; data_in = da; tick();
    op_in = OP_DEC; data_in = db; tick();
    idle_in();
    repeat (4) tick();
    ra  = 8'(ref_op(1, da, 1, 0));
    rb  = 8'(ref_op(2, db, 1, 0));
    pre = {1'b1, 2'b01, ra, 1'b1, 2'b10, rb, 11'd0};
    g   = {$urandom, $urandom};
    o   = '0;
    sen = 1'b1;
    for (int n = 0; n < L; n++) begin
      if (n == 10 || n == 20) begin
        scan_ce = 1'b0;
        sample();
        chk("scan_gap_hold", sout, pre[L-1-n]);
        adv();
      end
      scan_ce = 1'b1; sin = g[n];
      sample();
      o[n] = sout;
      chk("scan_out", sout, pre[L-1-n]);
      adv();
    end
    for (int n = 0; n < L; n++) begin
      scan_ce = 1'b1; sin = o[n];
      sample();
      chk("scan_back", sout, g[n]);
      adv();
    end
    sen = 1'b0; scan_ce = 1'b0; sin = 1'b0;
    out_ready = 1'b1;
    sample();
    chk("resume_valid", out_valid, 1);
    adv();
    drain();

    // Scan mode blocks the handshake; the held item survives.
    out_ready = 1'b0;
    in_valid = 1'b1; op_in = 2'($urandom_range(0, 3)); data_in = 8'($urandom_range(0, 255));
    tick();
    idle_in();
    repeat (3) tick();
    sen = 1'b1; scan_ce = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; op_in = OP_INC; data_in = 8'h5A;
    repeat (3) tick();
    sen = 1'b0;
    p0 = npop;
    drain();
    chk("scan_item_count", npop - p0, 1);

    // Random traffic against the scoreboard.
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      op_in     = in_valid ? 2'($urandom_range(0, 3)) : 2'b00;
      data_in   = in_valid ? 8'($urandom_range(0, 255)) : 8'h00;
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
